fe_pc_ctrl: RTL

FE_PC_CTRL -- requirements
Module: fe_pc_ctrl

---
 rtl/fe_pc_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/fe_pc_ctrl.sv
// Fetch-stage PC controller: sequences the fetch address, captures the FE latch,
// and applies branch redirects from AGEX with priority over DE stalls.
module fe_pc_ctrl #(
  parameter int                DBITS    = 32,
  parameter int                INSTBITS = 32,
  parameter logic [DBITS-1:0]  STARTPC  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                br_taken_i,
  input  logic [DBITS-1:0]    br_target_i,
  input  logic                stall_i,
  input  logic [INSTBITS-1:0] imem_rdata_i,
  output logic [DBITS-1:0]    pc_o,
  output logic                fe_valid_o,
  output logic [INSTBITS-1:0] fe_inst_o,
  output logic [DBITS-1:0]    fe_pc_o,
  output logic [DBITS-1:0]    fe_pcplus_o,
  output logic [DBITS-1:0]    fe_inst_count_o,
  output logic                squash_o,
  output logic [15:0]         redirect_cnt_o,
  output logic                misalign_err_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] REDIR = 2'd3;

  localparam logic [DBITS-1:0] PC_STEP   = DBITS'(4);
  localparam logic [DBITS-1:0] CNT_STEP  = DBITS'(1);
  localparam logic [DBITS-1:0] CNT_START = DBITS'(1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [DBITS-1:0] pc_q;
  logic [DBITS-1:0] count_q;
  logic [DBITS-1:0] pc_plus4;
  logic [DBITS-1:0] target_aligned;
  logic             fetch_en;

  assign pc_plus4       = pc_q + PC_STEP;
  assign target_aligned = {br_target_i[DBITS-1:2], 2'b00};
  // IDLE never fetches; a redirect or stall suppresses the fetch in any other state.
  assign fetch_en       = !br_taken_i && !stall_i && (state_q != IDLE);
  assign squash_o       = br_taken_i;
  assign pc_o           = pc_q;

  always_comb begin
    state_d = state_q;
    if (br_taken_i)          state_d = REDIR;
    else if (state_q == IDLE) state_d = RUN;
    else if (stall_i)        state_d = HOLD;
    else                     state_d = RUN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= STARTPC;
      count_q <= CNT_START;
    end else begin
      state_q <= state_d;
      if (br_taken_i) begin
        pc_q <= target_aligned;
      end else if (fetch_en) begin
        pc_q    <= pc_plus4;
        count_q <= count_q + CNT_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fe_valid_o      <= 1'b0;
      fe_inst_o       <= '0;
      fe_pc_o         <= '0;
      fe_pcplus_o     <= '0;
      fe_inst_count_o <= '0;
    end else begin
      if (br_taken_i || state_q == IDLE) begin
        fe_valid_o <= 1'b0;
      end else if (fetch_en) begin
        fe_valid_o      <= 1'b1;
        fe_inst_o       <= imem_rdata_i;
        fe_pc_o         <= pc_q;
        fe_pcplus_o     <= pc_plus4;
        fe_inst_count_o <= count_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_cnt_o <= '0;
      misalign_err_o <= 1'b0;
    end else if (br_taken_i) begin
      if (redirect_cnt_o != 16'hFFFF) redirect_cnt_o <= redirect_cnt_o + 16'd1;
      if (br_target_i[1:0] != 2'b00) misalign_err_o <= 1'b1;
    end
  end

endmodule
